// File: rtl/cfi_lp_tracker.sv
// Landing-pad state tracker: owns ELP/MPELP/LPE and turns landing-pad violations
// into a software-check exception request with a valid/ready handshake.
module cfi_lp_tracker #(
   parameter int unsigned XLEN          = 64,
   parameter logic [11:0] CSR_ADDR      = 12'h7C0,
   parameter int unsigned SWCHECK_CAUSE = 18,
   parameter int unsigned LP_TVAL       = 2
) (
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            commit_valid_i,
   input  logic [XLEN-1:0] commit_pc_i,
   input  logic            elp_set_i,
   input  logic            lp_fault_i,
   input  logic            trap_i,
   input  logic            mret_i,
   input  logic            csr_we_i,
   input  logic [11:0]     csr_addr_i,
   input  logic [XLEN-1:0] csr_wdata_i,
   output logic [XLEN-1:0] csr_rdata_o,
   output logic            csr_hit_o,
   output logic            lpe_o,
   output logic            elp_o,
   output logic            mpelp_o,
   output logic            ex_valid_o,
   input  logic            ex_ready_i,
   output logic [XLEN-1:0] ex_cause_o,
   output logic [XLEN-1:0] ex_tval_o,
   output logic [XLEN-1:0] ex_epc_o,
   output logic [15:0]     fault_cnt_o
);

   typedef enum logic [1:0] {IDLE, ARMED, PEND} state_e;

   state_e            state_q, state_d;
   logic              lpe_q, lpe_d;
   logic              mpelp_q, mpelp_d;
   logic [XLEN-1:0]   epc_q, epc_d;
   logic [XLEN-1:0]   cause_q, cause_d;
   logic [XLEN-1:0]   tval_q, tval_d;
   logic [15:0]       fault_cnt_q, fault_cnt_d;
   logic              csr_wr;
   logic              commit_arm;

   assign csr_hit_o  = (csr_addr_i == CSR_ADDR);
   assign csr_wr     = csr_we_i & csr_hit_o;
   assign commit_arm = commit_valid_i & elp_set_i;

   // NOTE: every always_comb target gets a default first so no path infers a latch.
   always_comb begin
      state_d     = state_q;
      lpe_d       = lpe_q;
      mpelp_d     = mpelp_q;
      epc_d       = epc_q;
      cause_d     = cause_q;
      tval_d      = tval_q;
      fault_cnt_d = fault_cnt_q;

      // CSR writes land in IDLE/ARMED only; later trap/mret assignments override them.
      if (state_q != PEND && csr_wr) begin
         lpe_d   = csr_wdata_i[0];
         mpelp_d = csr_wdata_i[2];
         if (csr_wdata_i[3]) fault_cnt_d = '0;
      end

      unique case (state_q)
         IDLE: begin
            if (mret_i) begin
               mpelp_d = 1'b0;
               if (mpelp_q & lpe_q) state_d = ARMED;
            end
            if (commit_arm & lpe_q) state_d = ARMED;
         end
         ARMED: begin
            if (trap_i) begin
               mpelp_d = 1'b1;
               state_d = IDLE;
            end else if (commit_valid_i & lp_fault_i) begin
               epc_d   = commit_pc_i;
               cause_d = XLEN'(SWCHECK_CAUSE);
               tval_d  = XLEN'(LP_TVAL);
               state_d = PEND;
            end else if (commit_valid_i & ~elp_set_i) begin
               state_d = IDLE;
            end else if (commit_arm) begin
               state_d = ARMED;
            end else if (csr_wr & ~csr_wdata_i[0]) begin
               state_d = IDLE;
            end
         end
         PEND: begin
            if (ex_ready_i) begin
               mpelp_d = 1'b1;
               if (fault_cnt_q != 16'hFFFF) fault_cnt_d = fault_cnt_q + 16'd1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         lpe_q       <= 1'b0;
         mpelp_q     <= 1'b0;
         epc_q       <= '0;
         cause_q     <= '0;
         tval_q      <= '0;
         fault_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         lpe_q       <= lpe_d;
         mpelp_q     <= mpelp_d;
         epc_q       <= epc_d;
         cause_q     <= cause_d;
         tval_q      <= tval_d;
         fault_cnt_q <= fault_cnt_d;
      end
   end

   assign lpe_o       = lpe_q;
   assign mpelp_o     = mpelp_q;
   assign elp_o       = (state_q != IDLE);
   assign ex_valid_o  = (state_q == PEND);
   assign ex_cause_o  = cause_q;
   assign ex_tval_o   = tval_q;
   assign ex_epc_o    = epc_q;
   assign fault_cnt_o = fault_cnt_q;

   always_comb begin
      csr_rdata_o = '0;
      if (csr_hit_o) begin
         csr_rdata_o[0]     = lpe_q;
         csr_rdata_o[1]     = elp_o;
         csr_rdata_o[2]     = mpelp_q;
         csr_rdata_o[31:16] = fault_cnt_q;
      end
   end

endmodule

// File: tb/tb_cfi_lp_tracker.sv
// Directed bench for cfi_lp_tracker: hand-computed vectors checked with immediate assertions.
module tb_cfi_lp_tracker;

   localparam int XLEN = 64;

   logic            clk_i = 1'b0;
   logic            rst_ni;
   logic            commit_valid_i;
   logic [XLEN-1:0] commit_pc_i;
   logic            elp_set_i;
   logic            lp_fault_i;
   logic            trap_i;
   logic            mret_i;
   logic            csr_we_i;
   logic [11:0]     csr_addr_i;
   logic [XLEN-1:0] csr_wdata_i;
   logic [XLEN-1:0] csr_rdata_o;
   logic            csr_hit_o;
   logic            lpe_o;
   logic            elp_o;
   logic            mpelp_o;
   logic            ex_valid_o;
   logic            ex_ready_i;
   logic [XLEN-1:0] ex_cause_o;
   logic [XLEN-1:0] ex_tval_o;
   logic [XLEN-1:0] ex_epc_o;
   logic [15:0]     fault_cnt_o;

   int n_vec = 0;
   int n_err = 0;

   cfi_lp_tracker dut (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .commit_valid_i(commit_valid_i), .commit_pc_i(commit_pc_i),
      .elp_set_i(elp_set_i), .lp_fault_i(lp_fault_i),
      .trap_i(trap_i), .mret_i(mret_i),
      .csr_we_i(csr_we_i), .csr_addr_i(csr_addr_i), .csr_wdata_i(csr_wdata_i),
      .csr_rdata_o(csr_rdata_o), .csr_hit_o(csr_hit_o),
      .lpe_o(lpe_o), .elp_o(elp_o), .mpelp_o(mpelp_o),
      .ex_valid_o(ex_valid_o), .ex_ready_i(ex_ready_i),
      .ex_cause_o(ex_cause_o), .ex_tval_o(ex_tval_o), .ex_epc_o(ex_epc_o),
      .fault_cnt_o(fault_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      commit_valid_i = 1'b0;
      commit_pc_i    = '0;
      elp_set_i      = 1'b0;
      lp_fault_i     = 1'b0;
      trap_i         = 1'b0;
      mret_i         = 1'b0;
      csr_we_i       = 1'b0;
      csr_wdata_i    = '0;
   endtask

   task automatic csr_write(input logic [XLEN-1:0] data);
      csr_we_i    = 1'b1;
      csr_wdata_i = data;
      tick();
      csr_we_i    = 1'b0;
   endtask

   task automatic commit(input logic [XLEN-1:0] pc, input logic set, input logic fault);
      commit_valid_i = 1'b1;
      commit_pc_i    = pc;
      elp_set_i      = set;
      lp_fault_i     = fault;
      tick();
      commit_valid_i = 1'b0;
      elp_set_i      = 1'b0;
      lp_fault_i     = 1'b0;
   endtask

   initial begin
      idle_inputs();
      ex_ready_i = 1'b0;
      csr_addr_i = 12'h7C0;
      rst_ni     = 1'b0;
      #12;
      rst_ni     = 1'b1;
      tick();

      // reset state and CSR decode
      check("rst_elp", elp_o, 0);
      check("rst_mpelp", mpelp_o, 0);
      check("rst_lpe", lpe_o, 0);
      check("rst_valid", ex_valid_o, 0);
      check("rst_cnt", fault_cnt_o, 0);
      check("rst_cause", ex_cause_o, 0);
      check("rst_rdata", csr_rdata_o, 0);
      check("hit", csr_hit_o, 1);
      csr_addr_i = 12'h7C1;
      #1;
      check("miss_hit", csr_hit_o, 0);
      csr_addr_i = 12'h7C0;

      // arm then consume the landing pad
      csr_write(64'h1);
      check("lpe_set", lpe_o, 1);
      check("rd_lpe", csr_rdata_o, 64'h1);
      commit(64'h1000, 1'b1, 1'b0);
      check("arm_elp", elp_o, 1);
      check("arm_rd", csr_rdata_o, 64'h3);
      commit(64'h1004, 1'b0, 1'b0);
      check("consume_elp", elp_o, 0);
      check("consume_valid", ex_valid_o, 0);

      // fault with stalled ready; PEND ignores trap/mret/CSR writes
      commit(64'h1FFC, 1'b1, 1'b0);
      commit(64'h2004, 1'b0, 1'b1);
      check("pend_valid1", ex_valid_o, 1);
      check("pend_cause", ex_cause_o, 64'd18);
      check("pend_tval", ex_tval_o, 64'd2);
      check("pend_epc", ex_epc_o, 64'h2004);
      trap_i = 1'b1; mret_i = 1'b1; csr_we_i = 1'b1; csr_wdata_i = 64'h4;
      commit(64'h3000, 1'b1, 1'b1);
      idle_inputs();
      check("pend_valid2", ex_valid_o, 1);
      check("pend_ign_lpe", lpe_o, 1);
      check("pend_ign_mpelp", mpelp_o, 0);
      check("pend_epc_hold", ex_epc_o, 64'h2004);
      tick();
      check("pend_valid3", ex_valid_o, 1);
      tick();
      check("pend_valid4", ex_valid_o, 1);
      check("pend_cause_hold", ex_cause_o, 64'd18);
      ex_ready_i = 1'b1;
      tick();
      ex_ready_i = 1'b0;
      check("acc_valid", ex_valid_o, 0);
      check("acc_mpelp", mpelp_o, 1);
      check("acc_elp", elp_o, 0);
      check("acc_cnt", fault_cnt_o, 16'd1);
      check("acc_rd", csr_rdata_o, 64'h10005);

      // trap saves ELP (beats same-cycle CSR write), mret restores it (beats CSR write)
      csr_write(64'h1);
      check("clr_mpelp", mpelp_o, 0);
      commit(64'h4000, 1'b1, 1'b0);
      trap_i = 1'b1;
      csr_write(64'h1);
      trap_i = 1'b0;
      check("trap_mpelp", mpelp_o, 1);
      check("trap_elp", elp_o, 0);
      mret_i = 1'b1;
      csr_write(64'h5);
      mret_i = 1'b0;
      check("mret_elp", elp_o, 1);
      check("mret_mpelp", mpelp_o, 0);
      trap_i = 1'b1;
      tick();
      trap_i = 1'b0;
      check("trap2_mpelp", mpelp_o, 1);
      csr_write(64'h4);
      check("lpe_off", lpe_o, 0);
      mret_i = 1'b1;
      tick();
      mret_i = 1'b0;
      check("mret_nolpe_elp", elp_o, 0);
      check("mret_nolpe_mpelp", mpelp_o, 0);

      // arming uses the pre-write LPE value
      commit(64'h5000, 1'b1, 1'b0);
      check("lpe0_noarm", elp_o, 0);
      csr_we_i = 1'b1; csr_wdata_i = 64'h1;
      commit(64'h5004, 1'b1, 1'b0);
      csr_we_i = 1'b0;
      check("samecyc_noarm", elp_o, 0);
      check("samecyc_lpe", lpe_o, 1);
      commit(64'h5008, 1'b1, 1'b0);
      check("nextarm", elp_o, 1);
      csr_write(64'h0);
      check("csr_disarm", elp_o, 0);
      csr_write(64'h1);

      // counter saturation and write-1-clear
      @(negedge clk_i);
      force dut.fault_cnt_q = 16'hFFFE;
      release dut.fault_cnt_q;
      #1;
      for (int i = 0; i < 2; i++) begin
         commit(64'h6000, 1'b1, 1'b0);
         commit(64'h6004, 1'b0, 1'b1);
         ex_ready_i = 1'b1;
         tick();
         ex_ready_i = 1'b0;
         check($sformatf("sat_cnt%0d", i), fault_cnt_o, 16'hFFFF);
      end
      check("sat_rd", csr_rdata_o[31:16], 16'hFFFF);
      csr_write(64'h9);
      check("cnt_clr", fault_cnt_o, 0);
      check("cnt_clr_rd", csr_rdata_o, 64'h1);

      // asynchronous reset while a request is pending
      commit(64'h7000, 1'b1, 1'b0);
      commit(64'h7008, 1'b0, 1'b1);
      check("pre_rst_valid", ex_valid_o, 1);
      #2;
      rst_ni = 1'b0;
      #1;
      check("arst_valid", ex_valid_o, 0);
      check("arst_elp", elp_o, 0);
      check("arst_lpe", lpe_o, 0);
      check("arst_epc", ex_epc_o, 0);
      check("arst_tval", ex_tval_o, 0);
      #10;
      rst_ni = 1'b1;
      tick();
      check("post_rst_valid", ex_valid_o, 0);
      check("post_rst_rd", csr_rdata_o, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/cfi_lp_tracker.md
Name: cfi_lp_tracker

Overview:
- Downstream consumer of the landing-pad checker FSM, which flags indirect-jump arming and landing-pad violations per committed instruction.
- Owns the architectural landing-pad state: ELP (expected landing pad), MPELP (ELP saved on trap) and LPE (enable).
- Converts a landing-pad violation into a software-check exception request to the commit/trap stage, using a valid/ready handshake.
- Exposes one CSR for control and status.

Parameters:
- XLEN, 64, data/address width of PC, CSR data and exception fields.
- CSR_ADDR, 12'h7C0, address of the landing-pad control/status CSR.
- SWCHECK_CAUSE, 18, value driven on ex_cause_o.
- LP_TVAL, 2, value driven on ex_tval_o (landing-pad fault code).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- commit_valid_i  in  1  an instruction commits this cycle
- commit_pc_i  in  XLEN  PC of the committing instruction
- elp_set_i  in  1  checker: committed instruction is an arming indirect jump
- lp_fault_i  in  1  checker: committed instruction violated the landing-pad expectation
- trap_i  in  1  trap entry taken (any cause) this cycle
- mret_i  in  1  mret commits this cycle
- csr_we_i  in  1  CSR write strobe
- csr_addr_i  in  12  CSR address
- csr_wdata_i  in  XLEN  CSR write data
- csr_rdata_o  out  XLEN  CSR read data, combinational, zero when not hit
- csr_hit_o  out  1  csr_addr_i == CSR_ADDR
- lpe_o  out  1  landing-pad enforcement enabled
- elp_o  out  1  landing pad currently expected
- mpelp_o  out  1  saved ELP
- ex_valid_o  out  1  exception request
- ex_ready_i  in  1  trap stage accepts the request
- ex_cause_o  out  XLEN  exception cause
- ex_tval_o  out  XLEN  exception tval
- ex_epc_o  out  XLEN  PC of the faulting instruction
- fault_cnt_o  out  16  saturating count of accepted landing-pad exceptions

Behaviour:
- Reset: state IDLE; lpe_o, elp_o, mpelp_o, ex_valid_o = 0; ex_cause_o, ex_tval_o, ex_epc_o = 0; fault_cnt_o = 0.
- State machine: IDLE, ARMED, PEND. elp_o = 1 in ARMED and PEND, 0 in IDLE. All outputs are registered except csr_rdata_o and csr_hit_o.
- IDLE:
  - commit_valid_i & elp_set_i & lpe_o -> ARMED next cycle.
  - lp_fault_i is ignored in IDLE.
  - mret_i: elp <= mpelp_o & lpe_o and mpelp <= 0. If the new elp is 1, go to ARMED.
- ARMED, priority order:
  1. trap_i: mpelp <= 1, go to IDLE.
  2. commit_valid_i & lp_fault_i: latch ex_epc_o <= commit_pc_i, go to PEND.
  3. commit_valid_i & ~elp_set_i: landing pad consumed, go to IDLE.
  4. commit_valid_i & elp_set_i: stay in ARMED.
  5. LPE cleared by a CSR write: go to IDLE.
- PEND:
  - ex_valid_o = 1. ex_cause_o = SWCHECK_CAUSE, ex_tval_o = LP_TVAL and ex_epc_o stay stable until ex_ready_i.
  - On ex_valid_o & ex_ready_i: mpelp <= 1, elp cleared, fault_cnt_o += 1 (saturates at 16'hFFFF), go to IDLE. ex_valid_o drops in the next cycle.
  - Latency: lp_fault_i commit in cycle N -> ex_valid_o high in cycle N+1.
  - While in PEND, trap_i, mret_i, commit inputs and CSR writes are ignored and dropped.
- CSR bit layout at CSR_ADDR:
  - bit0 LPE: read/write.
  - bit1 ELP: read-only.
  - bit2 MPELP: read/write.
  - bit3: write-1 clears fault_cnt; reads 0.
  - bits[31:16]: fault_cnt, read-only.
  - All other bits read 0.
- CSR write timing: the write takes effect at the clock edge. Arming decisions in the same cycle use the pre-write LPE value.
- Same-cycle events:
  - CSR write to MPELP together with trap_i in ARMED: the trap wins and mpelp = 1.
  - CSR write to MPELP together with mret_i in IDLE: mret wins and mpelp = 0.
- Reset mid-operation: an asynchronous rst_ni assertion forces reset values immediately, including dropping a pending request.

Test Plan:
- LPE=1 via CSR; commit elp_set_i at PC 0x1000, then a commit without a fault -> elp_o 1 for one cycle, then 0; ex_valid_o never asserts.
- LPE=1; arm, then commit lp_fault_i at PC 0x2004 with ex_ready_i=0 for 3 cycles -> ex_valid_o held 4 cycles with cause 18, tval 2, epc 0x2004. On ready, mpelp_o=1, elp_o=0, fault_cnt_o=1.
- Arm, then assert trap_i -> mpelp_o=1, elp_o=0. Then mret_i -> elp_o=1 (ARMED) and mpelp_o=0. Repeat with LPE cleared before the mret -> elp_o stays 0.
- LPE=0; commit elp_set_i -> elp_o stays 0. Then CSR write 0x1 in the same cycle as elp_set_i -> no arming; the next elp_set_i arms.
- Preload 65535 faults (force the counter or loop), take one more fault -> fault_cnt_o stays 16'hFFFF. CSR write with bit3=1 -> reads back 0 in bits[31:16].
- In PEND, assert rst_ni low mid-handshake -> ex_valid_o=0 and all state returns to reset values asynchronously.
